// File: rtl/beltwarn_alarm.sv
// Seat-belt alert timer: debounces W, then drives a blinking chime and a steady lamp.
// Optional macro BELTWARN_REARM_EN re-arms the alert after REARM_TICKS ticks in QUIET.
module beltwarn_alarm #(
    parameter int TICK_DIV    = 50000000,
    parameter int BLINK_TICKS = 1,
    parameter int ON_TICKS    = 6,
    parameter int DEB_CYCLES  = 1000,
    parameter int REARM_TICKS = 30
) (
    input  logic Clk,
    input  logic Rst,
    input  logic W,
    output logic Chime,
    output logic Light,
    output logic Timeout
);
    localparam int PRE_W   = $clog2(TICK_DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W  = $clog2(ON_TICKS + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0]  ON_LAST    = TICK_W'(ON_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    if (TICK_DIV < 2 || DEB_CYCLES < 1 || BLINK_TICKS < 1 || ON_TICKS < 1 || REARM_TICKS < 1) begin : g_bad_param
        $error("beltwarn_alarm: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ALERT, QUIET} state_t;

    state_t             state, state_n;
    logic               w_q, w_s;
    logic [DEB_W-1:0]   deb_cnt;
    logic [PRE_W-1:0]   presc;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               tick, chime_n;

    // A new level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            w_q     <= 1'b0;
            w_s     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            w_q <= W;
            if (w_q == w_s) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                w_s     <= w_q;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign tick = (presc == PRE_LAST);

`ifdef BELTWARN_REARM_EN
    localparam int RE_W = $clog2(REARM_TICKS + 1);
    localparam logic [RE_W-1:0] RE_LAST = RE_W'(REARM_TICKS - 1);
    logic [RE_W-1:0] rearm_cnt;

    always_ff @(posedge Clk) begin
        if (Rst || state_n != state)
            rearm_cnt <= '0;
        else if (tick && state == QUIET)
            rearm_cnt <= rearm_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_n = state;
        chime_n = 1'b0;
        case (state)
            IDLE: begin
                if (w_s) begin
                    state_n = ALERT;
                    chime_n = 1'b1;
                end
            end
            ALERT: begin
                chime_n = Chime;
                if (!w_s) begin
                    state_n = IDLE;
                    chime_n = 1'b0;
                end else if (tick && tick_cnt == ON_LAST) begin
                    // Chime is forced off here even if the blink phase is mid-high.
                    state_n = QUIET;
                    chime_n = 1'b0;
                end else if (tick && blink_cnt == BLINK_LAST) begin
                    chime_n = ~Chime;
                end
            end
            QUIET: begin
                if (!w_s) begin
                    state_n = IDLE;
`ifdef BELTWARN_REARM_EN
                end else if (tick && rearm_cnt == RE_LAST) begin
                    state_n = ALERT;
                    chime_n = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            Chime   <= 1'b0;
            Light   <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            state   <= state_n;
            Chime   <= chime_n;
            Light   <= (state_n != IDLE);
            Timeout <= (state_n == QUIET);
        end
    end

    // Prescaler and tick counters restart on every state change.
    always_ff @(posedge Clk) begin
        if (Rst || state_n != state) begin
            presc     <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && state == ALERT) begin
                tick_cnt  <= tick_cnt + 1'b1;
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_beltwarn_alarm.sv
// Bench for beltwarn_alarm: run-length expected waveform table plus hand-written re-arm check.
module tb_beltwarn_alarm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w   = 1'b0;
    logic chime, light, timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       w;
        int         reps;
        logic [2:0] exp;   // {Chime, Light, Timeout}
    } vec_t;

    typedef struct {
        logic [2:0] exp;
        string      tag;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    beltwarn_alarm #(
        .TICK_DIV(4), .BLINK_TICKS(2), .ON_TICKS(8), .DEB_CYCLES(3), .REARM_TICKS(3)
    ) dut (
        .Clk(clk), .Rst(rst), .W(w),
        .Chime(chime), .Light(light), .Timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive at negedge, queue what the next rising edge must produce, then check it.
    task automatic step(input logic r, input logic wv, input logic [2:0] e, input string tag);
        sb_t s;
        @(negedge clk);
        rst = r;
        w   = wv;
        sb.push_back('{exp: e, tag: tag});
        @(posedge clk);
        #1;
        s = sb.pop_front();
        checks++;
        if ({chime, light, timeout} !== s.exp) begin
            failures++;
            $display("FAIL %s got={chime,light,timeout}=%b exp=%b", s.tag, {chime, light, timeout}, s.exp);
        end
    endtask

    task automatic alert_period(input string tag);
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, {((i / 8) % 2 == 0), 2'b10}, $sformatf("%s_alert_c%0d", tag, i));
    endtask

    initial begin
        // 1: reset with W=1, release, full ALERT then QUIET
        tbl.push_back('{1'b1, 1'b1, 2, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 4, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b110});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b010});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b110});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b010});
        tbl.push_back('{1'b0, 1'b1, 10, 3'b011});
        // 5: reset in QUIET, fresh ALERT after 5 edges
        tbl.push_back('{1'b1, 1'b1, 1, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 4, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b110});
        tbl.push_back('{1'b0, 1'b1, 2, 3'b010});
        // 4: W drops at ALERT cycle 10, outputs clear 5 edges later, then full re-alert
        tbl.push_back('{1'b0, 1'b0, 4, 3'b010});
        tbl.push_back('{1'b0, 1'b0, 4, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 4, 3'b000});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b110});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b010});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b110});
        tbl.push_back('{1'b0, 1'b1, 8, 3'b010});
        tbl.push_back('{1'b0, 1'b1, 5, 3'b011});
        tbl.push_back('{1'b1, 1'b0, 2, 3'b000});
        // 3: 2-cycle pulses with 2-cycle gaps never pass the debouncer
        for (int k = 0; k < 6; k++) begin
            tbl.push_back('{1'b0, 1'b1, 2, 3'b000});
            tbl.push_back('{1'b0, 1'b0, 2, 3'b000});
        end

        foreach (tbl[i])
            for (int j = 0; j < tbl[i].reps; j++)
                step(tbl[i].rst, tbl[i].w, tbl[i].exp, $sformatf("vec%0d_c%0d", i, j));

        // 6: QUIET length with and without re-arm
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b000, $sformatf("q_deb_c%0d", i));
        alert_period("q1");
`ifdef BELTWARN_REARM_EN
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 3'b011, $sformatf("rearm_quiet_c%0d", i));
        alert_period("q2");
        step(1'b0, 1'b1, 3'b011, "rearm_quiet2");
`else
        for (int i = 0; i < 220; i++) step(1'b0, 1'b1, 3'b011, $sformatf("hold_quiet_c%0d", i));
`endif
        // W released from QUIET returns to IDLE after debounce
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b011, $sformatf("release_c%0d", i));
        step(1'b0, 1'b0, 3'b000, "release_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
